// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e        : arbiter FSM state encoding (IDLE, LAUNCH, WAIT_DONE)
//   UART_DATA_W        : default byte width
//   UART_FRAME_TIMEOUT : default clk cycles allowed from tx_start to tx_done.
//                        One 10-bit frame at 9600 baud from 100 MHz is
//                        104170 cycles, so this leaves generous margin.
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_e;

   localparam int UART_DATA_W        = 8;
   localparam int UART_FRAME_TIMEOUT = 200000;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: returns the first set bit of req_i found by
// scanning upward from ptr_i and wrapping past NUM_REQ-1 back to 0.
// Ports:
//   req_i     in  NUM_REQ  request vector
//   ptr_i     in  IDW      index with highest priority this cycle
//   winner_o  out IDW      selected index (0 when no request is set)
//   any_req_o out 1        at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [IDW-1:0]     winner_o,
   output logic               any_req_o
);

   int   idx;
   logic found;

   // Walk the requesters in priority order (ptr, ptr+1, ... with wrap) and
   // keep the first hit. ptr_i is always below NUM_REQ, so one subtraction
   // is enough to wrap.
   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req_i[idx[IDW-1:0]]) begin
            found    = 1'b1;
            winner_o = idx[IDW-1:0];
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. A grant is held for up to BURST_LEN back-to-back bytes, then
// priority rotates to the requester after the grantee. A watchdog abandons
// a frame whose tx_done never arrives and raises a sticky error.
//
// Handshake: a requester raises req_valid_i[i] with its byte on req_data_i
// and holds both until it sees the one-cycle req_ready_o[i] pulse; the byte
// was captured on the edge that raised req_ready_o. The transmitter receives
// a one-cycle tx_start_o with tx_data_o, which stays stable until the next
// launch, and answers with a one-cycle tx_done_i at the end of the stop bit.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   req_valid_i     per-requester byte pending
//   req_data_i      packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_ready_o     one-cycle accept pulse, one-hot or zero
//   tx_start_o      one-cycle launch pulse to the transmitter
//   tx_data_o       byte for the transmitter
//   tx_busy_i       transmitter is shifting a frame
//   tx_done_i       one-cycle end-of-frame pulse
//   grant_valid_o   a grant is active (LAUNCH or WAIT_DONE)
//   grant_id_o      current or last grantee
//   timeout_err_o   sticky watchdog flag
//   err_clr_i       clears timeout_err_o (a simultaneous new timeout wins)
//   state_o         debug view of the arbiter state
//   rr_ptr_o        debug view of the round-robin pointer
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = UART_DATA_W,
   parameter int BURST_LEN   = 4,
   parameter int TIMEOUT_CYC = UART_FRAME_TIMEOUT,
   parameter int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic                        tx_start_o,
   output logic [DATA_W-1:0]           tx_data_o,
   input  logic                        tx_busy_i,
   input  logic                        tx_done_i,
   output logic                        grant_valid_o,
   output logic [IDW-1:0]              grant_id_o,
   output logic                        timeout_err_o,
   input  logic                        err_clr_i,
   output arb_state_e                  state_o,
   output logic [IDW-1:0]              rr_ptr_o
);

   localparam int BCW = $clog2(BURST_LEN + 1);
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [IDW-1:0] LAST_ID     = IDW'(NUM_REQ - 1);
   localparam logic [BCW-1:0] BURST_MAX   = BCW'(BURST_LEN);
   localparam logic [WDW-1:0] WD_LAST     = WDW'(TIMEOUT_CYC - 1);

   arb_state_e          state_q;
   logic [NUM_REQ-1:0]  req_ready_q;
   logic                tx_start_q;
   logic [DATA_W-1:0]   tx_data_q;
   logic                grant_valid_q;
   logic [IDW-1:0]      grant_id_q;
   logic                timeout_err_q;
   logic [IDW-1:0]      rr_ptr_q;
   logic [BCW-1:0]      burst_cnt_q;
   logic [WDW-1:0]      wd_q;

   logic [IDW-1:0]      rr_ptr_d;
   logic [BCW-1:0]      burst_cnt_d;
   logic                burst_more;
   logic                wd_expired;
   logic [IDW-1:0]      pick_id;
   logic                pick_any;
   logic [DATA_W-1:0]   req_bytes [NUM_REQ];

   genvar g;
   for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data_i[g*DATA_W +: DATA_W];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_pick (
      .req_i     (req_valid_i),
      .ptr_i     (rr_ptr_q),
      .winner_o  (pick_id),
      .any_req_o (pick_any)
   );

   // Priority passes to the requester after the one just served.
   assign rr_ptr_d    = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
   assign burst_cnt_d = burst_cnt_q + 1'b1;
   // Keep the grant only if the grantee already has its next byte waiting
   // and the burst allowance is not used up.
   assign burst_more  = req_valid_i[grant_id_q] && (burst_cnt_d < BURST_MAX);
   assign wd_expired  = (wd_q == WD_LAST);

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
      onehot     = '0;
      onehot[id] = 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         req_ready_q   <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         timeout_err_q <= 1'b0;
         rr_ptr_q      <= '0;
         burst_cnt_q   <= '0;
         wd_q          <= '0;
      end else begin
         // Pulses last one cycle unless a branch below relaunches.
         req_ready_q <= '0;
         tx_start_q  <= 1'b0;

         // A timeout set later in this block overrides the clear.
         if (err_clr_i) begin
            timeout_err_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!tx_busy_i && pick_any) begin
                  grant_id_q    <= pick_id;
                  tx_data_q     <= req_bytes[pick_id];
                  burst_cnt_q   <= '0;
                  wd_q          <= '0;
                  tx_start_q    <= 1'b1;
                  req_ready_q   <= onehot(pick_id);
                  grant_valid_q <= 1'b1;
                  state_q       <= LAUNCH;
               end
            end

            LAUNCH: begin
               wd_q    <= '0;
               state_q <= WAIT_DONE;
            end

            WAIT_DONE: begin
               // tx_done is checked first so it wins over a coincident expiry.
               if (tx_done_i) begin
                  burst_cnt_q <= burst_cnt_d;
                  if (burst_more) begin
                     tx_data_q   <= req_bytes[grant_id_q];
                     tx_start_q  <= 1'b1;
                     req_ready_q <= onehot(grant_id_q);
                     state_q     <= LAUNCH;
                  end else begin
                     rr_ptr_q      <= rr_ptr_d;
                     grant_valid_q <= 1'b0;
                     state_q       <= IDLE;
                  end
               end else if (wd_expired) begin
                  // The stuck byte is treated as consumed; no retry.
                  timeout_err_q <= 1'b1;
                  rr_ptr_q      <= rr_ptr_d;
                  grant_valid_q <= 1'b0;
                  state_q       <= IDLE;
               end else if (wd_q != '1) begin
                  wd_q <= wd_q + 1'b1;
               end
            end

            default: begin
               grant_valid_q <= 1'b0;
               state_q       <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o   = req_ready_q;
   assign tx_start_o    = tx_start_q;
   assign tx_data_o     = tx_data_q;
   assign grant_valid_o = grant_valid_q;
   assign grant_id_o    = grant_id_q;
   assign timeout_err_o = timeout_err_q;
   assign state_o       = state_q;
   assign rr_ptr_o      = rr_ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with NUM_REQ=4, BURST_LEN=4,
// TIMEOUT_CYC=50. Producers and a transmitter model drive the DUT; every
// launch is checked against an expected queue by a separate monitor.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NUM_REQ     = 4;
   localparam int DATA_W      = 8;
   localparam int BURST_LEN   = 4;
   localparam int TIMEOUT_CYC = 50;
   localparam int IDW         = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- DUT ----------------
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      tx_start;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_busy   = 1'b0;
   logic                      busy_hold = 1'b0;
   logic                      tx_done   = 1'b0;
   logic                      grant_valid;
   logic [IDW-1:0]            grant_id;
   logic                      timeout_err;
   logic                      err_clr   = 1'b0;
   arb_state_e                state;
   logic [IDW-1:0]            rr_ptr;

   uart_tx_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .DATA_W      (DATA_W),
      .BURST_LEN   (BURST_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .tx_start_o    (tx_start),
      .tx_data_o     (tx_data),
      .tx_busy_i     (tx_busy | busy_hold),
      .tx_done_i     (tx_done),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id),
      .timeout_err_o (timeout_err),
      .err_clr_i     (err_clr),
      .state_o       (state),
      .rr_ptr_o      (rr_ptr)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   logic [IDW+DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0]     prod_q[NUM_REQ][$];
   int n_starts       = 0;
   int last_start_cyc = 0;
   int last_done_cyc  = -1000;
   int gap_a[64];
   int tx_lat  = 20;
   bit tx_mute = 1'b0;
   int tx_cnt  = 0;

   // ---------------- producers ----------------
   // Each requester presents the head of its queue and drops it on req_ready.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i] === 1'b1 && prod_q[i].size() > 0) begin
            void'(prod_q[i].pop_front());
         end
         req_valid[i] = (prod_q[i].size() > 0);
         req_data[i*DATA_W +: DATA_W] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
      end
   end

   // ---------------- transmitter model ----------------
   // tx_start seen in cycle t gives tx_done in cycle t+tx_lat; busy covers
   // cycles t..t+tx_lat. With tx_mute the done pulse is withheld.
   initial forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_start === 1'b1) begin
         tx_busy = 1'b1;
         tx_cnt  = tx_lat;
      end else if (tx_cnt > 0) begin
         tx_cnt--;
         if (tx_cnt == 0 && !tx_mute) begin
            tx_done       = 1'b1;
            last_done_cyc = cyc;
         end
      end else begin
         tx_busy = 1'b0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [IDW+DATA_W-1:0] mon_e;
   logic [NUM_REQ-1:0]    mon_ready;
   initial forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
         if (n_starts < 64) gap_a[n_starts] = cyc - last_done_cyc;
         last_start_cyc = cyc;
         n_starts++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_start got id=%0d data=%h, required none", grant_id, tx_data);
         end else begin
            mon_e     = exp_q.pop_front();
            mon_ready = 4'b0001 << mon_e[DATA_W +: IDW];
            if (tx_data !== mon_e[DATA_W-1:0] || grant_id !== mon_e[DATA_W +: IDW] ||
                req_ready !== mon_ready) begin
               errors++;
               $display("FAIL launch got id=%0d data=%h ready=%b, required id=%0d data=%h ready=%b",
                        grant_id, tx_data, req_ready, mon_e[DATA_W +: IDW], mon_e[DATA_W-1:0], mon_ready);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send(input int id, input logic [DATA_W-1:0] data);
      prod_q[id].push_back(data);
   endtask

   task automatic expect_tx(input int id, input logic [DATA_W-1:0] data);
      logic [IDW-1:0] idv;
      idv = IDW'(id);
      exp_q.push_back({idv, data});
   endtask

   task automatic wait_starts(input string name, input int target, input int budget);
      int k = 0;
      while (n_starts < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, n_starts, target);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while (grant_valid !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, grant_valid, 0);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_ready"},   req_ready,   0);
      check({tag, "_tx_start"},    tx_start,    0);
      check({tag, "_tx_data"},     tx_data,     0);
      check({tag, "_grant_valid"}, grant_valid, 0);
      check({tag, "_grant_id"},    grant_id,    0);
      check({tag, "_timeout_err"}, timeout_err, 0);
      check({tag, "_rr_ptr"},      rr_ptr,      0);
      check({tag, "_state"},       state,       IDLE);
   endtask

   // ---------------- global time limit ----------------
   initial begin
      #500000;
      $display("FAIL time_limit got cyc=%0d, required finish", cyc);
      $fatal(1, "time limit");
   end

   // ---------------- directed sequence ----------------
   int base;
   int t;
   int k;
   initial begin
      // Reset values, during and after reset.
      repeat (3) @(negedge clk);
      check_reset_values("rst_hold");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("rst_after");

      // Single request from 2.
      base = n_starts;
      send(2, 8'hA5);
      expect_tx(2, 8'hA5);
      wait_starts("single_start", base + 1, 20);
      wait_idle("single_idle", 40);
      check("single_rr_ptr", rr_ptr, 3);
      check("single_grant_kept", grant_id, 2);

      // Fairness: everyone has one byte; pointer at 3 so order is 3,0,1,2.
      base = n_starts;
      send(0, 8'h30); send(1, 8'h31); send(2, 8'h32); send(3, 8'h33);
      expect_tx(3, 8'h33); expect_tx(0, 8'h30); expect_tx(1, 8'h31); expect_tx(2, 8'h32);
      wait_starts("fair_starts", base + 4, 120);
      wait_idle("fair_idle", 40);
      for (int i = 1; i < 4; i++) check("fair_rotate_gap", gap_a[base + i], 2);
      check("fair_rr_ptr", rr_ptr, 3);

      // Burst cap: 1 has six bytes, 2 has one.
      base = n_starts;
      for (int i = 0; i < 6; i++) send(1, 8'h11 + 8'(i));
      send(2, 8'h21);
      for (int i = 0; i < 4; i++) expect_tx(1, 8'h11 + 8'(i));
      expect_tx(2, 8'h21);
      expect_tx(1, 8'h15); expect_tx(1, 8'h16);
      wait_starts("burst_starts", base + 7, 220);
      wait_idle("burst_idle", 40);
      for (int i = 1; i < 4; i++) check("burst_b2b_gap", gap_a[base + i], 1);
      check("burst_handoff_gap", gap_a[base + 4], 2);
      check("burst_regrant_gap", gap_a[base + 5], 2);
      check("burst_rr_ptr", rr_ptr, 2);

      // Busy gating.
      base = n_starts;
      busy_hold = 1'b1;
      send(0, 8'h40);
      expect_tx(0, 8'h40);
      repeat (10) @(negedge clk);
      check("busy_no_start", n_starts, base);
      busy_hold = 1'b0;
      k = cyc;
      wait_starts("busy_start", base + 1, 10);
      check("busy_release_latency", last_start_cyc, k + 1);
      wait_idle("busy_idle", 40);

      // Watchdog: transmitter never reports done.
      tx_mute = 1'b1;
      tx_lat  = 60;
      base = n_starts;
      send(3, 8'h50);
      expect_tx(3, 8'h50);
      wait_starts("wd_start", base + 1, 10);
      t = last_start_cyc;
      wait_cyc(t + 50);
      check("wd_err_before", timeout_err, 0);
      check("wd_grant_before", grant_valid, 1);
      wait_cyc(t + 51);
      check("wd_err_set", timeout_err, 1);
      check("wd_grant_dropped", grant_valid, 0);
      check("wd_state_idle", state, IDLE);
      check("wd_rr_ptr", rr_ptr, 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("wd_err_cleared", timeout_err, 0);
      wait_cyc(t + 65);
      tx_mute = 1'b0;

      // tx_done coincident with expiry: done wins.
      tx_lat = 50;
      base = n_starts;
      send(0, 8'h60);
      expect_tx(0, 8'h60);
      wait_starts("coin_start", base + 1, 10);
      t = last_start_cyc;
      wait_cyc(t + 51);
      check("coin_no_err", timeout_err, 0);
      check("coin_idle", grant_valid, 0);
      check("coin_rr_ptr", rr_ptr, 1);
      wait_cyc(t + 53);

      // Reset in the middle of a burst.
      tx_lat = 20;
      base = n_starts;
      send(2, 8'h71); send(2, 8'h72); send(2, 8'h73);
      expect_tx(2, 8'h71); expect_tx(2, 8'h72); expect_tx(2, 8'h73);
      wait_starts("mid_start", base + 1, 10);
      t = last_start_cyc;
      wait_cyc(t + 5);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("mid_rst");
      exp_q.delete();
      for (int i = 0; i < NUM_REQ; i++) prod_q[i].delete();
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(t + 25);
      base = n_starts;
      send(3, 8'h80); send(0, 8'h81);
      expect_tx(0, 8'h81); expect_tx(3, 8'h80);
      wait_starts("post_rst_starts", base + 2, 60);
      wait_idle("post_rst_idle", 40);
      check("post_rst_rr_ptr", rr_ptr, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
